stream_arbiter: RTL and testbench
=================================

# stream_arbiter

Round-robin arbiter that shares one registered valid/ready output stage between `NR` requester channels. Each beat is granted to one requester and captured into an internal output register with single-cycle latency. Multi-beat bursts are held by a lock that lasts until the requester's `iLast_AS` beat. The block sits in front of a downstream network stage wherever several producers feed one consumer.

## Interface
- `WD`, default 4: data width per channel.
- `NR`, default 4: number of requester channels, ≥2, not required to be a power of two.
- `WS`, default 2: index width, must equal clog2(`NR`).

- `iCLK`, in, 1: clock; all state updates on the rising edge.
- `iRST`, in, 1: reset, asynchronous and active-low.
- `iValid_AS`, in, `NR`: per-channel valid.
- `oReady_AS`, out, `NR`: per-channel ready; at most one bit is set.
- `iData_AS`, in, `NR*WD`: channel k data at bits [k*WD +: WD].
- `iLast_AS`, in, `NR`: per-channel end-of-burst flag, sampled with the data.
- `oValid_BS`, out, 1: output valid.
- `iReady_BS`, in, 1: downstream ready.
- `oData_BS`, out, `WD`: output data.
- `oSel_BS`, out, `WS`: index of the channel that sourced the current output beat.

## Operation
- **Output stage**
  - Acceptance signal: `w_acc = !r_vld || iReady_BS`.
  - `oValid_BS`, `oData_BS` and `oSel_BS` are driven directly from registers.
- **State**
  - State register: IDLE or LOCK.
  - `r_ptr` (`WS` bits) is the round-robin start index.
  - `r_own` (`WS` bits) is the owner of the current burst.
- **IDLE**
  - The candidate is the first k with `iValid_AS[k]=1`, scanning r_ptr, r_ptr+1, … modulo `NR`.
  - `oReady_AS[k]=w_acc` for the candidate only; all other bits are 0.
  - If no channel is valid, all ready bits are 0.
- **LOCK**
  - Only `r_own` is eligible: `oReady_AS[r_own]=w_acc`, all other bits 0, even when the owner is not valid.
- **Transfer on channel k**
  - Occurs when `iValid_AS[k] && oReady_AS[k]`.
  - Loads `r_dat`, sets `r_sel=k` and `r_vld=1`.
  - With `iLast_AS[k]=1`: set `r_ptr=(k+1) mod NR` (NR−1 wraps to 0) and go to or stay in IDLE.
  - With `iLast_AS[k]=0`: set `r_own=k` and go to or stay in LOCK; `r_ptr` is unchanged.
- **No transfer**
  - If `w_acc=1`: `r_vld` ← 0.
  - Otherwise `r_vld`, `r_dat` and `r_sel` hold.
- **Reset (`iRST=0`)**
  - Asynchronous clear: `r_vld=0`, `r_dat=0`, `r_sel=0`, `r_ptr=0`, `r_own=0`, state IDLE.
  - `oReady_AS` is forced to all-0 while `iRST=0`.
  - Reset in the middle of a burst drops the lock; the rest of the burst is treated as new requests.
- **Requester rules**
  - A requester holds valid, data and last stable until its transfer.
  - Valid must not depend combinationally on `oReady_AS`.
  - `oReady_AS` depends combinationally on `iValid_AS` in IDLE; this is permitted.
- **Single-beat request:** `iLast_AS=1` on the first beat, so the block never enters LOCK.

## Timing
- Latency: 1 cycle from input transfer to the beat appearing on `oValid_BS`/`oData_BS`/`oSel_BS`.
- Throughput: one beat per cycle with `iReady_BS=1`, including channel switches (no bubble when arbitration moves to another channel).
- Backpressure: while `oValid_BS=1` and `iReady_BS=0`, outputs hold and all `oReady_AS` bits are 0.
- Output beat consumed in the same cycle as a new transfer: the new beat replaces it at the next edge with no gap.
- Owner idle during a burst: bubbles appear on the output; the lock is not released until the `iLast_AS` beat.
- Reset values of outputs: `oValid_BS=0`, `oData_BS=0`, `oSel_BS=0`, `oReady_AS=0`.
- After reset release: first grant goes to the lowest-index valid channel.

## Test plan
1. **Reset:** hold `iRST=0` with all valids=1 → all outputs 0 and no transfers. Release, ch0–3 valid with last=1 → ch0 accepted on the first edge; `oSel_BS=0` and `oValid_BS=1` one cycle later.
2. **Fairness:** NR=4, all channels valid continuously, last=1, data=0xA+k, `iReady_BS=1` → `oSel_BS` sequence 0,1,2,3,0,1 on consecutive cycles with `oValid_BS` continuously 1, and `oData_BS` tracks the source.
3. **Burst lock:** ch1 sends 3 beats (last on the 3rd) while ch0/ch2 are valid throughout, and ch1 drops valid for 1 cycle after beat 1 →
   - no other channel is granted during the burst;
   - `oValid_BS` has a 1-cycle bubble;
   - the next grant after the last beat goes to ch2.
4. **Backpressure:** `iReady_BS=0` for 3 cycles with `oValid_BS=1` → `oData_BS`/`oSel_BS` stable and `oReady_AS=0`. Raise `iReady_BS` → the held beat is consumed and a new beat is accepted in the same cycle.
5. **Non-power-of-two wrap:** NR=3, WS=2, all channels valid → `oSel_BS` 0,1,2,0,1; index 3 never appears.
6. **Mid-burst reset:** ch2 owns an incomplete burst, assert `iRST=0` asynchronously → `oValid_BS` falls immediately without waiting for a clock. After release with ch0 and ch2 both valid → ch0 is granted first.

Source files
------------

// File: rtl/stream_arbiter_if.sv
// Handshake bundle for stream_arbiter: NR requester channels on the A side,
// one registered output stream on the B side.
interface stream_arbiter_if #(
  parameter int WD = 4,
  parameter int NR = 4,
  parameter int WS = 2
);
  logic [NR-1:0]    iValid_AS;
  logic [NR-1:0]    oReady_AS;
  logic [NR*WD-1:0] iData_AS;
  logic [NR-1:0]    iLast_AS;
  logic             oValid_BS;
  logic             iReady_BS;
  logic [WD-1:0]    oData_BS;
  logic [WS-1:0]    oSel_BS;

  // Arbiter side.
  modport slave (
    input  iValid_AS, iData_AS, iLast_AS, iReady_BS,
    output oReady_AS, oValid_BS, oData_BS, oSel_BS
  );

  // Producer/consumer side.
  modport master (
    output iValid_AS, iData_AS, iLast_AS, iReady_BS,
    input  oReady_AS, oValid_BS, oData_BS, oSel_BS
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage from NR
// requesters; multi-beat bursts keep the grant until their last beat.
module stream_arbiter #(
  parameter int WD = 4,
  parameter int NR = 4,
  parameter int WS = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  stream_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t        state_q, state_d;
  logic          vld_q, vld_d;
  logic [WD-1:0] dat_q, dat_d;
  logic [WS-1:0] sel_q, sel_d;
  logic [WS-1:0] ptr_q, ptr_d;
  logic [WS-1:0] own_q, own_d;

  logic          w_acc;
  logic          cand_found;
  logic [WS-1:0] cand_idx;
  logic [WS-1:0] gnt_idx;
  logic          gnt_en;
  logic          xfer;
  logic [NR-1:0] ready;
  int            idx;

  // Scan from the highest offset down so the lowest offset past ptr_q wins.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NR) idx = idx - NR;
      if (bus.iValid_AS[idx]) begin
        cand_found = 1'b1;
        cand_idx   = WS'(idx);
      end
    end
  end

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    own_d   = own_q;

    w_acc   = !vld_q || bus.iReady_BS;
    gnt_idx = (state_q == LOCK) ? own_q : cand_idx;
    // A locked owner keeps its ready even while it is not valid.
    gnt_en  = iRST && w_acc && ((state_q == LOCK) || cand_found);
    ready   = '0;
    if (gnt_en) ready[gnt_idx] = 1'b1;
    xfer    = gnt_en && bus.iValid_AS[gnt_idx];

    if (xfer) begin
      vld_d = 1'b1;
      dat_d = bus.iData_AS[int'(gnt_idx)*WD +: WD];
      sel_d = gnt_idx;
      if (bus.iLast_AS[gnt_idx]) begin
        ptr_d   = (gnt_idx == WS'(NR - 1)) ? '0 : gnt_idx + WS'(1);
        state_d = IDLE;
      end else begin
        own_d   = gnt_idx;
        state_d = LOCK;
      end
    end else if (w_acc) begin
      vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  assign bus.oReady_AS = ready;
  assign bus.oValid_BS = vld_q;
  assign bus.oData_BS  = dat_q;
  assign bus.oSel_BS   = sel_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed self-checking bench for stream_arbiter: a 4-channel instance and a
// 3-channel instance for the non-power-of-two wrap.
module tb_stream_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_arbiter_if #(.WD(4), .NR(4), .WS(2)) bus4 ();
  stream_arbiter_if #(.WD(4), .NR(3), .WS(2)) bus3 ();

  stream_arbiter #(.WD(4), .NR(4), .WS(2)) u_dut4 (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus4)
  );

  stream_arbiter #(.WD(4), .NR(3), .WS(2)) u_dut3 (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 2 time units after each rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d);
    bus4.iValid_AS = v;
    bus4.iLast_AS  = l;
    bus4.iData_AS  = d;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    drive4(4'b0000, 4'b1111, 16'h0000);
    bus4.iReady_BS = 1'b1;
    bus3.iValid_AS = 3'b000;
    bus3.iLast_AS  = 3'b111;
    bus3.iData_AS  = 12'h000;
    bus3.iReady_BS = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive4(4'b1111, 4'b1111, 16'hDCBA);
    bus4.iReady_BS = 1'b1;
    bus3.iValid_AS = 3'b000;
    bus3.iLast_AS  = 3'b111;
    bus3.iData_AS  = 12'h000;
    bus3.iReady_BS = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (bus4.oValid_BS !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus4.oValid_BS); end
    checks++; if (bus4.oData_BS !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus4.oData_BS); end
    checks++; if (bus4.oSel_BS !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus4.oSel_BS); end
    checks++; if (bus4.oReady_AS !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus4.oReady_AS); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0001) begin failures++; $display("FAIL release_ready got=%b exp=0001", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oValid_BS !== 1'b1) begin failures++; $display("FAIL release_valid got=%b exp=1", bus4.oValid_BS); end
    checks++; if (bus4.oSel_BS !== 2'd0) begin failures++; $display("FAIL release_sel got=%0d exp=0", bus4.oSel_BS); end
    checks++; if (bus4.oData_BS !== 4'hA) begin failures++; $display("FAIL release_data got=%h exp=a", bus4.oData_BS); end
  endtask

  task automatic test_fairness;
    logic [1:0] exp_sel [6];
    logic [3:0] exp_dat [6];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
    apply_reset();
    drive4(4'b1111, 4'b1111, 16'hDCBA);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus4.oValid_BS !== 1'b1) begin failures++; $display("FAIL fair_valid[%0d] got=%b exp=1", i, bus4.oValid_BS); end
      checks++; if (bus4.oSel_BS !== exp_sel[i]) begin failures++; $display("FAIL fair_sel[%0d] got=%0d exp=%0d", i, bus4.oSel_BS, exp_sel[i]); end
      checks++; if (bus4.oData_BS !== exp_dat[i]) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, bus4.oData_BS, exp_dat[i]); end
    end
  endtask

  task automatic test_burst_lock;
    apply_reset();
    // One single beat on ch0 moves the pointer to ch1.
    drive4(4'b0001, 4'b1111, 16'h0001);
    tick();
    drive4(4'b0111, 4'b1101, 16'h0351);
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0010) begin failures++; $display("FAIL burst_ready_b1 got=%b exp=0010", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oSel_BS !== 2'd1 || bus4.oData_BS !== 4'h5) begin failures++; $display("FAIL burst_beat1 got=%0d/%h exp=1/5", bus4.oSel_BS, bus4.oData_BS); end
    drive4(4'b0101, 4'b1101, 16'h0351);
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0010) begin failures++; $display("FAIL burst_ready_idle got=%b exp=0010", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oValid_BS !== 1'b0) begin failures++; $display("FAIL burst_bubble got=%b exp=0", bus4.oValid_BS); end
    drive4(4'b0111, 4'b1101, 16'h0361);
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0010) begin failures++; $display("FAIL burst_ready_b2 got=%b exp=0010", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oValid_BS !== 1'b1 || bus4.oSel_BS !== 2'd1 || bus4.oData_BS !== 4'h6) begin failures++; $display("FAIL burst_beat2 got=%b/%0d/%h exp=1/1/6", bus4.oValid_BS, bus4.oSel_BS, bus4.oData_BS); end
    drive4(4'b0111, 4'b1111, 16'h0371);
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0010) begin failures++; $display("FAIL burst_ready_b3 got=%b exp=0010", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oSel_BS !== 2'd1 || bus4.oData_BS !== 4'h7) begin failures++; $display("FAIL burst_beat3 got=%0d/%h exp=1/7", bus4.oSel_BS, bus4.oData_BS); end
    drive4(4'b0101, 4'b1111, 16'h0371);
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0100) begin failures++; $display("FAIL burst_next_ready got=%b exp=0100", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oSel_BS !== 2'd2 || bus4.oData_BS !== 4'h3) begin failures++; $display("FAIL burst_next got=%0d/%h exp=2/3", bus4.oSel_BS, bus4.oData_BS); end
  endtask

  task automatic test_backpressure;
    apply_reset();
    drive4(4'b1111, 4'b1111, 16'hDCBA);
    tick();
    bus4.iReady_BS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus4.oReady_AS !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus4.oReady_AS); end
      tick();
      checks++; if (bus4.oValid_BS !== 1'b1 || bus4.oSel_BS !== 2'd0 || bus4.oData_BS !== 4'hA) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/a", i, bus4.oValid_BS, bus4.oSel_BS, bus4.oData_BS); end
    end
    bus4.iReady_BS = 1'b1;
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0010) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0010", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oValid_BS !== 1'b1 || bus4.oSel_BS !== 2'd1 || bus4.oData_BS !== 4'hB) begin failures++; $display("FAIL bp_resume got=%b/%0d/%h exp=1/1/b", bus4.oValid_BS, bus4.oSel_BS, bus4.oData_BS); end
  endtask

  task automatic test_npot_wrap;
    logic [1:0] exp_sel [5];
    logic [3:0] exp_dat [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    exp_dat = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2};
    apply_reset();
    bus3.iValid_AS = 3'b111;
    bus3.iLast_AS  = 3'b111;
    bus3.iData_AS  = 12'h321;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus3.oValid_BS !== 1'b1 || bus3.oSel_BS !== exp_sel[i]) begin failures++; $display("FAIL npot_sel[%0d] got=%b/%0d exp=1/%0d", i, bus3.oValid_BS, bus3.oSel_BS, exp_sel[i]); end
      checks++; if (bus3.oData_BS !== exp_dat[i]) begin failures++; $display("FAIL npot_data[%0d] got=%h exp=%h", i, bus3.oData_BS, exp_dat[i]); end
    end
    bus3.iValid_AS = 3'b000;
  endtask

  task automatic test_mid_burst_reset;
    apply_reset();
    drive4(4'b0100, 4'b0000, 16'h0900);
    tick();
    drive4(4'b0101, 4'b0001, 16'h0801);
    tick();
    checks++; if (bus4.oSel_BS !== 2'd2 || bus4.oData_BS !== 4'h8) begin failures++; $display("FAIL mbr_lock got=%0d/%h exp=2/8", bus4.oSel_BS, bus4.oData_BS); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.oValid_BS !== 1'b0) begin failures++; $display("FAIL mbr_async_valid got=%b exp=0", bus4.oValid_BS); end
    checks++; if (bus4.oReady_AS !== 4'b0000) begin failures++; $display("FAIL mbr_async_ready got=%b exp=0000", bus4.oReady_AS); end
    tick();
    drive4(4'b0101, 4'b0101, 16'h0801);
    rst_n = 1'b1;
    #1;
    checks++; if (bus4.oReady_AS !== 4'b0001) begin failures++; $display("FAIL mbr_release_ready got=%b exp=0001", bus4.oReady_AS); end
    tick();
    checks++; if (bus4.oValid_BS !== 1'b1 || bus4.oSel_BS !== 2'd0 || bus4.oData_BS !== 4'h1) begin failures++; $display("FAIL mbr_first got=%b/%0d/%h exp=1/0/1", bus4.oValid_BS, bus4.oSel_BS, bus4.oData_BS); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive4(4'b0000, 4'b1111, 16'h0000);
    bus4.iReady_BS = 1'b1;
    bus3.iValid_AS = 3'b000;
    bus3.iLast_AS  = 3'b111;
    bus3.iData_AS  = 12'h000;
    bus3.iReady_BS = 1'b1;
    #2;
    test_reset();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_npot_wrap();
    test_mid_burst_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
